// File: rtl/sdp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdp_fifo_ctrl
// Brief    : FIFO controller placed in front of a simple dual-port RAM with a
//            2-cycle read latency. It prefetches RAM reads into a 3-entry
//            output buffer to give a first-word-fall-through valid/ready port
//            that sustains one word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_fifo_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_BASE2    = 4,
  parameter int ALMFULL_THRESH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    almfull,
  output logic                    overflow,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_ready,
  output logic [DEPTH_BASE2+1:0]  count,
  output logic                    ram_we,
  output logic [DEPTH_BASE2-1:0]  ram_waddr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [DEPTH_BASE2-1:0]  ram_raddr,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  // RAM occupancy that means every entry is in use
  localparam logic [DEPTH_BASE2:0] c_full_cnt = {1'b1, {DEPTH_BASE2{1'b0}}};
  localparam logic [DEPTH_BASE2:0] c_alm_cnt  = (DEPTH_BASE2+1)'(ALMFULL_THRESH);

  logic [DEPTH_BASE2-1:0] r_wptr;
  logic [DEPTH_BASE2-1:0] r_rptr;
  logic [DEPTH_BASE2:0]   r_ram_cnt;
  logic                   r_v1;
  logic                   r_v2;
  logic                   r_overflow;
  logic [1:0]             r_ob_cnt;
  logic [DATA_WIDTH-1:0]  r_ob     [0:2];
  logic [DATA_WIDTH-1:0]  w_ob_nxt [0:2];

  logic                   w_wr_acc;
  logic                   w_pop;
  logic                   w_issue;
  logic [2:0]             w_pending;
  logic [1:0]             w_tail;

  // Flags are decoded straight from registered occupancy
  assign full     = (r_ram_cnt == c_full_cnt);
  assign almfull  = (r_ram_cnt >= c_alm_cnt);
  assign overflow = r_overflow;

  // Push path goes straight to the RAM write port
  assign w_wr_acc  = wr_en & ~full;
  assign ram_we    = w_wr_acc;
  assign ram_waddr = r_wptr;
  assign ram_din   = wr_data;

  // Reads are issued only while the buffer plus in-flight reads leave room
  assign w_pop     = rd_valid & rd_ready;
  assign w_pending = {1'b0, r_ob_cnt} + {2'b00, r_v1} + {2'b00, r_v2} - {2'b00, w_pop};
  assign w_issue   = (r_ram_cnt != '0) & (w_pending < 3'd3);
  assign ram_raddr = r_rptr;

  // Head word is gated so an emptied buffer never exposes a stale entry
  assign rd_valid = (r_ob_cnt != 2'd0);
  assign rd_data  = rd_valid ? r_ob[0] : '0;

  assign count = {1'b0, r_ram_cnt}
               + (DEPTH_BASE2+2)'(r_v1)
               + (DEPTH_BASE2+2)'(r_v2)
               + (DEPTH_BASE2+2)'(r_ob_cnt);

  // Returning word lands behind whatever survives this cycle's pop
  assign w_tail = r_ob_cnt - {1'b0, w_pop};

  // Next output-buffer contents: shift on pop, then drop in the RAM return
  always_comb begin
    w_ob_nxt[0] = w_pop ? r_ob[1] : r_ob[0];
    w_ob_nxt[1] = w_pop ? r_ob[2] : r_ob[1];
    w_ob_nxt[2] = r_ob[2];
    if (r_v2) begin
      case (w_tail)
        2'd0:    w_ob_nxt[0] = ram_dout;
        2'd1:    w_ob_nxt[1] = ram_dout;
        default: w_ob_nxt[2] = ram_dout;
      endcase
    end
  end

  // Write pointer, read pointer and RAM occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_issue)  r_rptr <= r_rptr + 1'b1;
      r_ram_cnt <= r_ram_cnt + (DEPTH_BASE2+1)'(w_wr_acc) - (DEPTH_BASE2+1)'(w_issue);
    end
  end

  // Track the two RAM read stages; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_issue;
      r_v2 <= r_v1;
    end
  end

  // Dropped push is reported one cycle later
  always_ff @(posedge clk) begin
    if (rst) r_overflow <= 1'b0;
    else     r_overflow <= wr_en & full;
  end

  // Output buffer storage and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ob_cnt <= 2'd0;
      r_ob[0]  <= '0;
      r_ob[1]  <= '0;
      r_ob[2]  <= '0;
    end else begin
      r_ob_cnt <= r_ob_cnt + {1'b0, r_v2} - {1'b0, w_pop};
      r_ob[0]  <= w_ob_nxt[0];
      r_ob[1]  <= w_ob_nxt[1];
      r_ob[2]  <= w_ob_nxt[2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_fifo_ctrl
// Brief    : Self-checking bench for sdp_fifo_ctrl with an attached 2-cycle
//            RAM model, a queue-based reference model and directed tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdp_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_ready = 1'b0;
  logic        full, almfull, overflow, rd_valid;
  logic [31:0] rd_data;
  logic [5:0]  count;
  logic        ram_we;
  logic [3:0]  ram_waddr, ram_raddr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;

  int checks = 0;
  int errors = 0;

  sdp_fifo_ctrl #(.DATA_WIDTH(32), .DEPTH_BASE2(4), .ALMFULL_THRESH(12)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almfull(almfull), .overflow(overflow),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Attached RAM: raddr registered, then dout registered
  logic [31:0] mem [0:15];
  logic [3:0]  raddr_q = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    raddr_q  <= ram_raddr;
    ram_dout <= mem[raddr_q];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Every held word, oldest first. A word leaves the RAM when issued and is
  // visible to the consumer three cycles after its issue cycle.
  typedef struct { logic [31:0] d; bit iss; int t; } ent_t;
  ent_t q[$];
  int   cyc = 0;
  bit   m_init = 0;
  bit   m_ovf = 0;
  bit   m_pop, m_issue, m_acc, m_full;

  function automatic int m_down();
    int n = 0;
    foreach (q[i]) if (q[i].iss) n++;
    return n;
  endfunction
  function automatic int m_ramw();
    return q.size() - m_down();
  endfunction
  function automatic bit m_valid();
    return (q.size() > 0) && q[0].iss && (cyc >= q[0].t + 3);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_ovf  = 0;
        m_init = 1;
      end else if (m_init) begin
        m_pop   = m_valid() && rd_ready;
        m_full  = (m_ramw() == 16);
        m_issue = (m_ramw() > 0) && (m_down() - int'(m_pop) < 3);
        m_acc   = wr_en && !m_full;
        m_ovf   = wr_en && m_full;
        if (m_pop) void'(q.pop_front());
        if (m_issue) begin
          for (int i = 0; i < q.size(); i++) begin
            if (!q[i].iss) begin
              q[i].iss = 1;
              q[i].t   = cyc;
              break;
            end
          end
        end
        if (m_acc) q.push_back('{d: wr_data, iss: 1'b0, t: 0});
      end
      cyc++;
    end
  end

  // Compare DUT against the model every cycle once reset has been seen
  int max_count = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("m_rd_valid", rd_valid, m_valid());
        if (m_valid()) chk("m_rd_data", rd_data, q[0].d);
        chk("m_count", count, q.size());
        chk("m_full", full, m_ramw() == 16);
        chk("m_almfull", almfull, m_ramw() >= 12);
        chk("m_overflow", overflow, m_ovf);
        chk("m_ram_we", ram_we, wr_en && (m_ramw() != 16));
        if (ram_we) chk("m_ram_din", ram_din, wr_data);
        if (int'(count) > max_count) max_count = int'(count);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle's inputs just after the edge, then settle for sampling
  task automatic step(input bit we, input logic [31:0] d, input bit rdy);
    @(posedge clk); #1;
    rst = 1'b0; wr_en = we; wr_data = d; rd_ready = rdy;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int idx, ridx, first, nval, last;

    // Test 1: reset state and single-word latency
    do_reset();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_full", full, 0);
    chk("rst_almfull", almfull, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count", count, 0);
    chk("rst_ram_we", ram_we, 0);
    step(1, 32'hA5A50001, 1);
    chk("t1_c0_we", ram_we, 1);
    for (int c = 1; c <= 4; c++) begin
      step(0, 0, 1);
      chk("t1_count", count, 1);
      chk("t1_valid", rd_valid, c == 4);
    end
    chk("t1_data", rd_data, 32'hA5A50001);
    step(0, 0, 1);
    chk("t1_count_after", count, 0);

    // Test 2: fill to capacity with consumer stalled
    for (int c = 0; c < 20; c++) begin
      step(1, c, 0);
      if (c == 14) chk("t2_almfull_c14", almfull, 0);
      if (c == 15) chk("t2_almfull_c15", almfull, 1);
      if (c == 18) chk("t2_full_c18", full, 0);
      if (c == 19) begin
        chk("t2_full_c19", full, 1);
        chk("t2_count_c19", count, 19);
        chk("t2_we_c19", ram_we, 0);
      end
    end
    step(0, 0, 0);
    chk("t2_overflow_pulse", overflow, 1);
    step(0, 0, 0);
    chk("t2_overflow_clear", overflow, 0);
    chk("t2_count_hold", count, 19);
    idx = 0;
    for (int c = 0; c < 60 && idx < 19; c++) begin
      step(0, 0, 1);
      if (rd_valid) begin
        chk("t2_drain_data", rd_data, idx);
        idx++;
      end
    end
    chk("t2_drain_n", idx, 19);
    step(0, 0, 1);

    // Test 3: back-to-back streaming
    first = -1; nval = 0; last = -1;
    for (int c = 0; c < 200; c++) begin
      step(c < 100, c, 1);
      if (rd_valid) begin
        if (first < 0) first = c;
        chk("t3_data", rd_data, nval);
        nval++;
        last = c;
      end
    end
    chk("t3_first", first, 4);
    chk("t3_nvalid", nval, 100);
    chk("t3_last", last, 103);

    // Test 4: random traffic, model checks every cycle
    for (int c = 0; c < 1000; c++)
      step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 50);
    for (int c = 0; c < 40; c++) step(0, 0, 1);
    chk("t4_max_count_le19", max_count <= 19, 1);
    chk("t4_empty", count, 0);

    // Test 5: wrap-around with a 10-cycle consumer stall
    idx = 0; ridx = 0;
    for (int c = 0; c < 300 && ridx < 40; c++) begin
      step(idx < 40, 32'h500 + idx, !(c >= 12 && c < 22));
      if (ram_we) idx++;
      if (rd_valid && rd_ready) begin
        chk("t5_data", rd_data, 32'h500 + ridx);
        ridx++;
      end
    end
    chk("t5_rx_n", ridx, 40);
    chk("t5_tx_n", idx, 40);
    step(0, 0, 1);

    // Test 6: reset with two reads in flight
    for (int c = 0; c < 3; c++) step(1, 32'hDEAD0000 + c, 0);
    @(posedge clk); #1;
    rst = 1'b1; wr_en = 1'b0; rd_ready = 1'b0;
    #2;
    chk("t6_count_pre", count, 3);
    step(0, 0, 1);
    chk("t6_valid_post", rd_valid, 0);
    chk("t6_count_post", count, 0);
    chk("t6_data_post", rd_data, 0);
    step(1, 32'h1234, 1);
    for (int c = 1; c <= 4; c++) begin
      step(0, 0, 1);
      chk("t6_valid", rd_valid, c == 4);
    end
    chk("t6_data", rd_data, 32'h1234);
    step(0, 0, 1);
    step(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdp_fifo_ctrl.md
Name: sdp_fifo_ctrl

Overview:
FIFO controller that sits directly in front of an sdp_ram instance. It drives the RAM write and read ports and consumes the RAM's read data.
- Accepts pushes from a producer.
- Issues RAM reads ahead of demand to hide the RAM's fixed 2-cycle read latency (raddr registered, then dout registered).
- Presents a first-word-fall-through valid/ready output through a 3-entry output buffer, sustaining 1 word/cycle.

Parameters:
DATA_WIDTH, 32, word width; must match the attached RAM.
DEPTH_BASE2, 4, log2 of RAM entries; must match the attached RAM.
ALMFULL_THRESH, 12, RAM occupancy at or above which almfull asserts.

Ports:
clk  input  1  clock; all state on posedge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  push request.
wr_data  input  DATA_WIDTH  push data.
full  output  1  RAM occupancy == 2**DEPTH_BASE2.
almfull  output  1  RAM occupancy >= ALMFULL_THRESH.
overflow  output  1  one-cycle pulse: push dropped because full.
rd_valid  output  1  rd_data holds the head word.
rd_data  output  DATA_WIDTH  head word.
rd_ready  input  1  consumer pops when rd_valid & rd_ready.
count  output  DEPTH_BASE2+2  total words held (RAM + in flight + output buffer).
ram_we  output  1  to RAM we.
ram_waddr  output  DEPTH_BASE2  to RAM waddr.
ram_din  output  DATA_WIDTH  to RAM din.
ram_raddr  output  DEPTH_BASE2  to RAM raddr.
ram_dout  input  DATA_WIDTH  from RAM dout; valid 2 cycles after ram_raddr is presented.

Behaviour:
- State:
  - wptr, rptr: DEPTH_BASE2 bits, wrap naturally.
  - ram_cnt: DEPTH_BASE2+1 bits.
  - In-flight valids v1, v2.
  - Output buffer: 3 entries, ob_cnt 0..3, FIFO order.
- Push side:
  - wr_acc = wr_en & ~full.
  - ram_we = wr_acc; ram_waddr = wptr; ram_din = wr_data (all combinational).
  - wptr increments on wr_acc.
  - overflow = wr_en & full, registered: it pulses the cycle after the dropped push.
  - A push while full is dropped even if a pop occurs in the same cycle.
- Issue:
  - pop = rd_valid & rd_ready.
  - issue = (ram_cnt != 0) & (ob_cnt + v1 + v2 - pop < 3).
  - ram_raddr = rptr, combinational, driven every cycle. rptr increments on issue.
  - v1 <= issue; v2 <= v1.
  - On v2, ram_dout is written into the output buffer tail in that same cycle.
  - Invariant: ob_cnt + v1 + v2 <= 3. The buffer never overflows.
- ram_cnt update:
  - ram_cnt <= ram_cnt + wr_acc - issue.
  - A slot is freed on issue. A same-cycle write into a just-issued slot is safe: the RAM has already latched raddr, and its write lands after the read.
  - A word written in cycle T is issuable no earlier than T+1, so there is no read-during-write hazard.
- Output:
  - rd_valid = (ob_cnt != 0); rd_data = buffer head.
  - ob_cnt <= ob_cnt + v2 - pop. Simultaneous capture and pop are both honoured.
- Latency:
  - Push at cycle T into an empty FIFO: issue T+1, ram_dout valid T+3, rd_valid T+4.
  - Steady streaming with rd_ready=1: one word per cycle, no bubbles.
- Flags:
  - full = (ram_cnt == 2**DEPTH_BASE2); almfull = (ram_cnt >= ALMFULL_THRESH). Both combinational from registered state.
  - count = ram_cnt + v1 + v2 + ob_cnt.
  - Total capacity = 2**DEPTH_BASE2 + 3.
- Reset:
  - Clears wptr, rptr, ram_cnt, v1, v2, ob_cnt and the overflow register.
  - Output values during/after reset: rd_valid=0, rd_data=0, full=0, almfull=0, overflow=0, count=0, ram_we=0 (when wr_en=0).
  - RAM contents are not cleared.
  - Reset mid-operation: in-flight RAM returns are discarded because v1/v2 are cleared. No stale word ever appears on rd_data.
- Ordering: strict FIFO. No loss or duplication under any rd_ready/wr_en pattern.

Test Plan:
1. Reset, then push 0xA5A50001 at cycle 0 with rd_ready=1 -> rd_valid=1 with rd_data=0xA5A50001 first at cycle 4; count=1 over cycles 1-4, then 0.
2. rd_ready=0, push 20 words 0..19 back-to-back -> full rises after the 19th accepted push; count=19; the 20th push sets overflow for one cycle; draining yields 0..18.
3. 100 back-to-back pushes with rd_ready=1 -> after 4-cycle latency rd_valid stays high for 100 consecutive cycles; data in order 0..99.
4. Random 50% rd_ready and 70% wr_en over 1000 cycles -> scoreboard matches in order; count never exceeds 19; ob_cnt never exceeds 3.
5. Wrap-around: stream 40 words through DEPTH_BASE2=4 with an intermittent stall of rd_ready=0 for 10 cycles -> pointers wrap twice; data intact; almfull asserts while ram_cnt>=12.
6. Two reads in flight (v1=v2=1), assert rst one cycle -> next cycle rd_valid=0 and count=0, stale words never output; then push 0x1234 -> read back 0x1234 at push cycle +4.
